// File: rtl/instgen_tile.sv
// Convolution instruction generator: walks output pixels and channel groups, buffering one instruction per cycle.
// Optional performance counters are enabled by defining INSTGEN_TILE_PERF_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

module instgen_tile #(
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int XLEN       = `XLEN,
    parameter int LANES      = 8,
    parameter int FIFO_DEPTH = 4
) (
`ifdef INSTGEN_TILE_PERF_EN
    output logic [XLEN-1:0]       perf_inst_cnt,
    output logic [XLEN-1:0]       perf_stall_cnt,
`endif
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] feature_baseaddr,
    input  logic [ADDR_WIDTH-1:0] kernel_baseaddr,
    input  logic [ADDR_WIDTH-1:0] output_baseaddr,
    input  logic [XLEN-1:0]       feature_width,
    input  logic [XLEN-1:0]       feature_chin,
    input  logic [XLEN-1:0]       feature_chout,
    input  logic [XLEN-1:0]       kernel_sizeh,
    input  logic [XLEN-1:0]       kernel_sizew,
    input  logic [XLEN-1:0]       stride,
    input  logic [XLEN-1:0]       output_width,
    input  logic [XLEN-1:0]       output_height,
    input  logic                  has_bias,
    input  logic                  has_relu,
    input  logic                  csrcmd_valid,
    output logic                  instgen_ready,
    input  logic                  abort,
    output logic                  inst_valid,
    input  logic                  decoder_ready,
    output logic [ADDR_WIDTH-1:0] inst_feature_addr,
    output logic [ADDR_WIDTH-1:0] inst_kernel_addr,
    output logic [ADDR_WIDTH-1:0] inst_wb_addr,
    output logic [XLEN-1:0]       inst_wb_ch_offset,
    output logic [LANES-1:0]      inst_lane_mask,
    output logic                  inst_has_bias,
    output logic                  inst_has_relu,
    output logic                  conv_complete
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW = 3 * ADDR_WIDTH + XLEN + LANES + 2;

    typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_t;
    state_t state_reg, state_next;

    logic [XLEN-1:0]       out_w_reg, out_h_reg, chout_reg;
    logic [ADDR_WIDTH-1:0] stride_reg, row_step_reg, kern_step_reg, kern_base_reg;
    logic                  has_bias_reg, has_relu_reg;
    logic [XLEN-1:0]       oh_reg, ow_reg, ch_off_reg;
    logic [ADDR_WIDTH-1:0] row_reg, feat_reg, kern_reg, wb_reg;

    logic [EW-1:0]         mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_reg, rd_ptr_reg;
    logic [PW:0]           count_reg;

    logic                  empty, full, push, pop, accept, zero_geom;
    logic                  last_g, last_ow, last_oh, flush;
    logic [LANES-1:0]      lane_mask;
    logic [EW-1:0]         head;

    assign empty      = (count_reg == '0);
    assign full       = (count_reg == (PW+1)'(FIFO_DEPTH));
    assign pop        = !empty && decoder_ready;
    assign accept     = (state_reg == IDLE) && csrcmd_valid;
    assign flush      = abort && (state_reg != IDLE);
    assign push       = (state_reg == GEN) && !abort && (!full || pop);
    assign zero_geom  = (output_width == '0) || (output_height == '0) || (feature_chout == '0);
    assign last_g     = ({1'b0, ch_off_reg} + (XLEN+1)'(LANES)) >= {1'b0, chout_reg};
    assign last_ow    = (ow_reg == out_w_reg - XLEN'(1));
    assign last_oh    = (oh_reg == out_h_reg - XLEN'(1));

    // Lane i is live iff its absolute output channel exists.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_mask
            assign lane_mask[gi] = ({1'b0, ch_off_reg} + (XLEN+1)'(gi)) < {1'b0, chout_reg};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next    = state_reg;
        conv_complete = 1'b0;
        case (state_reg)
            IDLE:  if (csrcmd_valid) state_next = zero_geom ? DRAIN : GEN;
            GEN: begin
                if (abort) state_next = IDLE;
                else if (push && last_g && last_ow && last_oh) state_next = DRAIN;
            end
            DRAIN: begin
                if (abort) state_next = IDLE;
                else if (empty || (count_reg == (PW+1)'(1) && pop)) begin
                    state_next    = IDLE;
                    conv_complete = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Geometry latch and running address accumulators.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_w_reg     <= '0;
            out_h_reg     <= '0;
            chout_reg     <= '0;
            stride_reg    <= '0;
            row_step_reg  <= '0;
            kern_step_reg <= '0;
            kern_base_reg <= '0;
            has_bias_reg  <= 1'b0;
            has_relu_reg  <= 1'b0;
            oh_reg        <= '0;
            ow_reg        <= '0;
            ch_off_reg    <= '0;
            row_reg       <= '0;
            feat_reg      <= '0;
            kern_reg      <= '0;
            wb_reg        <= '0;
        end else if (accept) begin
            out_w_reg     <= output_width;
            out_h_reg     <= output_height;
            chout_reg     <= feature_chout;
            stride_reg    <= ADDR_WIDTH'(stride);
            row_step_reg  <= ADDR_WIDTH'(stride) * ADDR_WIDTH'(feature_width);
            kern_step_reg <= (ADDR_WIDTH'(feature_chin) * ADDR_WIDTH'(kernel_sizeh)
                              * ADDR_WIDTH'(kernel_sizew)) << $clog2(LANES);
            kern_base_reg <= kernel_baseaddr;
            has_bias_reg  <= has_bias;
            has_relu_reg  <= has_relu;
            oh_reg        <= '0;
            ow_reg        <= '0;
            ch_off_reg    <= '0;
            row_reg       <= feature_baseaddr;
            feat_reg      <= feature_baseaddr;
            kern_reg      <= kernel_baseaddr;
            wb_reg        <= output_baseaddr;
        end else if (push) begin
            if (!last_g) begin
                ch_off_reg <= ch_off_reg + XLEN'(LANES);
                kern_reg   <= kern_reg + kern_step_reg;
            end else begin
                ch_off_reg <= '0;
                kern_reg   <= kern_base_reg;
                wb_reg     <= wb_reg + ADDR_WIDTH'(1);
                if (!last_ow) begin
                    ow_reg   <= ow_reg + XLEN'(1);
                    feat_reg <= feat_reg + stride_reg;
                end else begin
                    ow_reg   <= '0;
                    oh_reg   <= oh_reg + XLEN'(1);
                    row_reg  <= row_reg + row_step_reg;
                    feat_reg <= row_reg + row_step_reg;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            if (push && !pop)      count_reg <= count_reg + (PW+1)'(1);
            else if (!push && pop) count_reg <= count_reg - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= {feat_reg, kern_reg, wb_reg, ch_off_reg, lane_mask,
                                has_bias_reg, has_relu_reg};
    end

    // Fields read as zero whenever nothing is buffered.
    assign head          = empty ? '0 : mem[rd_ptr_reg];
    assign inst_valid    = !empty;
    assign instgen_ready = (state_reg == IDLE);
    assign {inst_feature_addr, inst_kernel_addr, inst_wb_addr, inst_wb_ch_offset,
            inst_lane_mask, inst_has_bias, inst_has_relu} = head;

`ifdef INSTGEN_TILE_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst || accept) begin
            perf_inst_cnt  <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (pop && perf_inst_cnt != '1)
                perf_inst_cnt <= perf_inst_cnt + XLEN'(1);
            if (inst_valid && !decoder_ready && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + XLEN'(1);
        end
    end
`endif

endmodule

// File: tb/tb_instgen_tile.sv
// Scoreboard bench for instgen_tile: a loop-nest model queues expected instructions, the monitor pops on handshake.
`timescale 1ns/1ps
module tb_instgen_tile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] feature_baseaddr = '0, kernel_baseaddr = '0, output_baseaddr = '0;
    logic [31:0] feature_width = '0, feature_chin = '0, feature_chout = '0;
    logic [31:0] kernel_sizeh = '0, kernel_sizew = '0, stride = '0;
    logic [31:0] output_width = '0, output_height = '0;
    logic        has_bias = 1'b0, has_relu = 1'b0;
    logic        csrcmd_valid = 1'b0, abort = 1'b0, decoder_ready = 1'b0;
    logic        instgen_ready, inst_valid, conv_complete;
    logic [31:0] inst_feature_addr, inst_kernel_addr, inst_wb_addr, inst_wb_ch_offset;
    logic [7:0]  inst_lane_mask;
    logic        inst_has_bias, inst_has_relu;
`ifdef INSTGEN_TILE_PERF_EN
    logic [31:0] perf_inst_cnt, perf_stall_cnt;
`endif

    instgen_tile #(.ADDR_WIDTH(32), .XLEN(32), .LANES(8), .FIFO_DEPTH(4)) dut (
`ifdef INSTGEN_TILE_PERF_EN
        .perf_inst_cnt(perf_inst_cnt),
        .perf_stall_cnt(perf_stall_cnt),
`endif
        .clk(clk), .rst(rst),
        .feature_baseaddr(feature_baseaddr), .kernel_baseaddr(kernel_baseaddr),
        .output_baseaddr(output_baseaddr),
        .feature_width(feature_width), .feature_chin(feature_chin), .feature_chout(feature_chout),
        .kernel_sizeh(kernel_sizeh), .kernel_sizew(kernel_sizew), .stride(stride),
        .output_width(output_width), .output_height(output_height),
        .has_bias(has_bias), .has_relu(has_relu),
        .csrcmd_valid(csrcmd_valid), .instgen_ready(instgen_ready), .abort(abort),
        .inst_valid(inst_valid), .decoder_ready(decoder_ready),
        .inst_feature_addr(inst_feature_addr), .inst_kernel_addr(inst_kernel_addr),
        .inst_wb_addr(inst_wb_addr), .inst_wb_ch_offset(inst_wb_ch_offset),
        .inst_lane_mask(inst_lane_mask), .inst_has_bias(inst_has_bias),
        .inst_has_relu(inst_has_relu), .conv_complete(conv_complete)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [137:0] exp_q[$];

    task automatic check_val(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // kind: 0 run to completion, 1 abort at cycle stop_at, 2 reset at cycle stop_at
    task automatic run_layer(input logic [31:0] fb, input logic [31:0] kb, input logic [31:0] ob,
                             input logic [31:0] fw, input logic [31:0] chin, input logic [31:0] chout,
                             input logic [31:0] kh, input logic [31:0] kw, input logic [31:0] st,
                             input logic [31:0] ow_w, input logic [31:0] oh_h,
                             input logic bias, input logic relu,
                             input int rmode, input int kind, input int stop_at);
        logic [31:0]  feat, kern, wb, off;
        logic [7:0]   mask;
        logic [137:0] cur, prev_fields, exp;
        logic         nz, done, stopped, prev_stall;
        int           c, budget, pops, stalls;
        exp_q.delete();
        for (int oh = 0; oh < int'(oh_h); oh++)
            for (int ow = 0; ow < int'(ow_w); ow++)
                for (int g = 0; g * 8 < int'(chout); g++) begin
                    feat = fb + oh * st * fw + ow * st;
                    kern = kb + g * 8 * chin * kh * kw;
                    wb   = ob + oh * ow_w + ow;
                    off  = g * 8;
                    for (int i = 0; i < 8; i++) mask[i] = (g * 8 + i < int'(chout));
                    exp_q.push_back({feat, kern, wb, off, mask, bias, relu});
                end
        nz = (ow_w != 0) && (oh_h != 0) && (chout != 0);
        budget = exp_q.size() * 4 + 50;
        feature_baseaddr = fb; kernel_baseaddr = kb; output_baseaddr = ob;
        feature_width = fw; feature_chin = chin; feature_chout = chout;
        kernel_sizeh = kh; kernel_sizew = kw; stride = st;
        output_width = ow_w; output_height = oh_h; has_bias = bias; has_relu = relu;
        check_val("ready_idle", instgen_ready, 1);
        csrcmd_valid = 1'b1;
        @(posedge clk); #1;
        csrcmd_valid = 1'b0;
        c = 0; done = 0; stopped = 0; prev_stall = 0; pops = 0; stalls = 0;
        prev_fields = '0;
        while (!done && !stopped && c < budget) begin
            decoder_ready = (rmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            csrcmd_valid  = (rmode != 0) ? ($urandom_range(0, 7) == 0) : 1'b0;
            if (kind != 0 && c == stop_at) begin
                csrcmd_valid = 1'b0;
                if (kind == 1) begin
                    abort = 1'b1;
                    #1;
                    check_val("abort_no_cc", conv_complete, 0);
                    @(posedge clk); #1;
                    abort = 1'b0;
                end else begin
                    rst = 1'b1;
                    #1;
                    check_val("rst_async_valid", inst_valid, 0);
                    check_val("rst_async_fields", {inst_feature_addr, inst_wb_ch_offset, inst_lane_mask}, 0);
                    @(posedge clk); #1;
                    rst = 1'b0;
                end
                check_val("stop_ready", instgen_ready, 1);
                check_val("stop_valid", inst_valid, 0);
                check_val("stop_cc", conv_complete, 0);
                stopped = 1;
            end else begin
                #1;
                cur = {inst_feature_addr, inst_kernel_addr, inst_wb_addr, inst_wb_ch_offset,
                       inst_lane_mask, inst_has_bias, inst_has_relu};
                if (nz && c == 0) check_val("lat_c0", inst_valid, 0);
                if (nz && c == 1) check_val("lat_c1", inst_valid, 1);
                if (!nz && c == 0) check_val("zero_cc", conv_complete, 1);
                if (prev_stall) check_val("stable", cur, prev_fields);
                if (inst_valid && decoder_ready) begin
                    pops++;
                    if (exp_q.size() == 0) check_val("extra_inst", cur, 0);
                    else begin
                        exp = exp_q.pop_front();
                        check_val("inst", cur, exp);
                    end
                end
                if (inst_valid && !decoder_ready) stalls++;
                prev_stall  = inst_valid && !decoder_ready;
                prev_fields = cur;
                if (conv_complete) begin
                    done = 1;
                    check_val("cc_after_last", exp_q.size(), 0);
                end
                @(posedge clk); #1;
                c++;
            end
        end
        csrcmd_valid  = 1'b0;
        decoder_ready = 1'b0;
        if (kind == 0) begin
            check_val("completed", done, 1);
            check_val("post_ready", instgen_ready, 1);
            check_val("post_valid", inst_valid, 0);
            check_val("cc_pulse", conv_complete, 0);
            $display("layer %0dx%0d chout=%0d: %0d pops, %0d stalls, %0d cycles", ow_w, oh_h, chout, pops, stalls, c);
`ifdef INSTGEN_TILE_PERF_EN
            check_val("perf_inst", perf_inst_cnt, pops);
            check_val("perf_stall", perf_stall_cnt, stalls);
`endif
        end else begin
            repeat (3) begin
                @(posedge clk); #1;
                check_val("stop_quiet", {conv_complete, inst_valid}, 0);
            end
            $display("layer stopped (kind=%0d) at cycle %0d after %0d pops", kind, stop_at, pops);
        end
        exp_q.delete();
    endtask

    initial begin
        #2;
        check_val("rst_ready", instgen_ready, 1);
        check_val("rst_valid", inst_valid, 0);
        check_val("rst_cc", conv_complete, 0);
        check_val("rst_fields", {inst_feature_addr, inst_kernel_addr, inst_wb_addr,
                                 inst_wb_ch_offset, inst_lane_mask, inst_has_bias, inst_has_relu}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        // fb, kb, ob, fw, chin, chout, kh, kw, st, ow, oh, bias, relu, rmode, kind, stop_at
        run_layer(32'h1000, 32'h8000, 32'h40000, 28, 3, 64, 3, 3, 1, 26, 26, 1, 1, 0, 0, 0);
        run_layer(32'h100, 32'h2000, 32'h3000, 10, 4, 20, 3, 3, 1, 3, 2, 0, 1, 1, 0, 0);
        run_layer(32'h500, 32'h0, 32'h900, 28, 2, 8, 3, 3, 2, 13, 13, 1, 0, 0, 0, 0);
        run_layer(32'h10, 32'h20, 32'h30, 8, 1, 8, 1, 1, 1, 4, 0, 0, 0, 0, 0, 0);
        run_layer(32'h10, 32'h20, 32'h30, 8, 2, 16, 3, 3, 1, 4, 4, 0, 0, 1, 1, 7);
        run_layer(32'h10, 32'h20, 32'h30, 8, 2, 16, 3, 3, 1, 4, 4, 1, 0, 1, 2, 9);
        run_layer(32'hFFFF_FFF0, 32'h7, 32'h44, 12, 5, 13, 2, 2, 1, 5, 3, 1, 1, 1, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
